demux_buffered: RTL
===================

# demux_buffered

Buffered 1-to-2 demultiplexer: routes 8-bit data words from one valid/ready input channel to one of two valid/ready output channels, selected per word by `in_sel`. It sits on the return side of the datapath select multiplexers, distributing a single producer's results, such as ALU or writeback values, to two independent consumers. Each output has its own small FIFO, so a stalled consumer does not block traffic already buffered for the other. Word order is preserved per output.

## Interface
Parameters:
- `WIDTH`, default 8: data word width.
- `DEPTH`, default 2: entries per output FIFO; power of two, ≥ 2.

Ports:
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `RESET`  in  1: synchronous, active-high reset.
- `in_data`  in  WIDTH: input word.
- `in_sel`  in  1: destination, 0 → out0, 1 → out1.
- `in_valid`  in  1: input word present.
- `in_ready`  out  1: block accepts the word this cycle.
- `out0_data`  out  WIDTH: head word of FIFO 0.
- `out0_valid`  out  1: FIFO 0 non-empty.
- `out0_ready`  in  1: consumer 0 takes the head word.
- `out1_data`, `out1_valid`, `out1_ready`: same as the out0 ports, for FIFO 1.
- `out0_count`, `out1_count`  out  $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes `in_data` to the tail of FIFO[`in_sel`]. The other FIFO's contents are untouched.
- `in_ready` = !full[`in_sel`] || (`outN_ready` && `outN_valid` for N = `in_sel`). It is combinational from `in_sel`, the selected FIFO's count and the selected `outN_ready`, with no path from `in_data`.
- Pop: `outN_valid && outN_ready` at a rising edge removes the head of FIFO N and advances the read pointer.
- `outN_valid` = (countN != 0). `outN_data` = storage[rd_ptrN], registered storage only. When the FIFO is empty, `outN_data` holds the last-read entry's value (don't-care for the consumer).
- Read/write pointers wrap modulo DEPTH. Count is tracked separately (0..DEPTH) so that full and empty are unambiguous.
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance. This is legal when full (only via the ready term above) and when holding exactly one entry.
- Push on one FIFO with a pop on the other in the same cycle: the two FIFOs are fully independent.
- Source rule: while `in_valid && !in_ready`, the source holds `in_data` and `in_sel` stable. A word blocked for a full output therefore stalls the input, including words behind it destined for the other output. This head-of-line blocking is intended.
- `in_valid` low: no push, regardless of `in_sel`.
- Pop of an empty FIFO (`outN_ready` high, `outN_valid` low) is ignored.
- Reset: pointers and counts clear to 0, and storage clears to 0. All buffered data is discarded, including reset asserted mid-transfer; a push or pop in the reset cycle has no effect.

## Timing
- Reset values: `out0_valid` = `out1_valid` = 0, `out0_data` = `out1_data` = 0, both counts = 0.
- `in_ready` is 1 in the reset cycle's aftermath, since both FIFOs are empty.
- Latency: a word pushed at edge k into an empty FIFO appears on `outN_data` with `outN_valid` = 1 in the cycle after edge k. The minimum is 1 cycle, with no same-cycle bypass.
- Throughput: 1 word/cycle sustained per output while its consumer holds ready high. Aggregate input throughput is 1 word/cycle.
- Counts update at the same edge as the push/pop that changes them.
- Full FIFO with consumer ready: the input is accepted that cycle with zero bubble.

## Test plan
- Reset, then push 0x11 (sel 0) and 0x22 (sel 1) on consecutive cycles with both readies high. Required: each word appears one cycle after its push on the correct port; the opposite port stays `valid` = 0.
- Hold `out0_ready` = 0 and push 0xA1, 0xA2, 0xA3 to sel 0 (DEPTH = 2). Required: `out0_count` reaches 2, then `in_ready` = 0 with 0xA3 held. Raising `out0_ready` pops 0xA1 and accepts 0xA3 in the same cycle; outputs follow in order 0xA2, 0xA3.
- Out0 full and stalled, source presents 0xB0 sel 0 followed by 0xC0 sel 1. Required: `in_ready` = 0 and FIFO 1 stays empty (head-of-line blocking) until out0 drains.
- Stream 0x00..0x0F alternating sel with random `outN_ready`. Required: each output receives its subsequence in order with no loss or duplication, exercising pointer wrap and simultaneous push/pop on both FIFOs.
- Fill FIFO 1 with 0x5A, 0x5B, then assert RESET for one cycle with `in_valid` = 1. Required: next cycle both counts = 0, both valids = 0, data outputs = 0, and the word presented during reset is not stored.
- `out0_ready` = 1 on an empty FIFO for 3 cycles with no push. Required: count stays 0 and no underflow (pointers unchanged).

Source files
------------

// File: rtl/demux_buffered.sv
`default_nettype none
// ============================================================================
// Module      : demux_buffered
// Description : 1-to-2 valid/ready demultiplexer with an independent FIFO per
//               output; word order is preserved per output.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_buffered #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out0_data,
    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [WIDTH-1:0]           out1_data,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [$clog2(DEPTH):0]     out0_count,
    output logic [$clog2(DEPTH):0]     out1_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [1:0]        w_rdy;
    logic [1:0]        w_valid;
    logic [c_CW-1:0]   w_cnt  [2];
    logic [WIDTH-1:0]  w_data [2];

    assign w_rdy = {out1_ready, out0_ready};

    // A full FIFO can still accept when its head leaves in the same cycle.
    assign in_ready = (w_cnt[in_sel] != c_FULL) || (w_rdy[in_sel] && w_valid[in_sel]);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [c_AW-1:0]  r_wr;
            logic [c_AW-1:0]  r_rd;
            logic [c_CW-1:0]  r_cnt;
            logic             w_push;
            logic             w_pop;

            assign w_push     = in_valid && in_ready && (in_sel == gi[0]);
            assign w_pop      = w_valid[gi] && w_rdy[gi];
            assign w_valid[gi] = (r_cnt != '0);
            assign w_cnt[gi]  = r_cnt;
            assign w_data[gi] = r_mem[r_rd];

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_wr  <= '0;
                    r_rd  <= '0;
                    r_cnt <= '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        r_mem[j] <= '0;
                    end
                end else begin
                    if (w_push) begin
                        r_mem[r_wr] <= in_data;
                        r_wr        <= r_wr + c_AW'(1);
                    end
                    if (w_pop) begin
                        r_rd <= r_rd + c_AW'(1);
                    end
                    if (w_push && !w_pop) begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end else if (w_pop && !w_push) begin
                        r_cnt <= r_cnt - c_CW'(1);
                    end
                end
            end
        end
    endgenerate

    assign out0_data  = w_data[0];
    assign out1_data  = w_data[1];
    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign out0_count = w_cnt[0];
    assign out1_count = w_cnt[1];

endmodule
`default_nettype wire
